// File: rtl/mem_map_pkg.sv
// Address map, MMIO register offsets and STATUS bit positions shared by the
// data-bus responder and its testbench.
package mem_map_pkg;

  localparam logic [3:0] RAM_REGION  = 4'h0;
  localparam logic [3:0] MMIO_REGION = 4'h1;

  // MMIO registers are decoded on address bits [3:2] only.
  localparam logic [1:0] OFF_TXDATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_MTIME    = 2'd2;
  localparam logic [1:0] OFF_MTIMECMP = 2'd3;

  localparam int ST_TMR   = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; the head word is read straight
// from storage and forced to zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers,
  // and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_responder.sv
// Far end of the core's data bus: combinational reads, edge-committed writes,
// word RAM plus MMIO console TX FIFO, cycle timer and compare flag.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] mem_data_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            irq_o
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [XLEN-1:0]   ram [RAM_DEPTH];
  logic [XLEN-1:0]   mtime;
  logic [XLEN-1:0]   mtimecmp;
  logic              tmr_flag;
  logic              ovf;
  logic              fifo_full;
  logic              fifo_empty;
  logic [XLEN-1:0]   status_word;

  logic [3:0]        region;
  logic [1:0]        offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram;
  logic              is_mmio;
  logic              wr_ok;
  logic              ram_we;
  logic              tx_push;
  logic              tx_pop;
  logic              we_status;
  logic              we_mtime;
  logic              we_mtimecmp;
  logic              unused_addr_bits;

  assign region  = mem_addr_i[XLEN-1:XLEN-4];
  assign offset  = mem_addr_i[3:2];
  assign ram_idx = mem_addr_i[RAM_AW+1:2];
  assign is_ram  = (region == RAM_REGION);
  assign is_mmio = (region == MMIO_REGION);
  assign unused_addr_bits = ^{mem_addr_i[XLEN-5:RAM_AW+2], mem_addr_i[1:0]};

  // Reset blocks every write, including the RAM, for the cycle it is high.
  assign wr_ok       = mem_we_i && !rst_i;
  assign ram_we      = wr_ok && is_ram;
  assign tx_push     = wr_ok && is_mmio && (offset == OFF_TXDATA);
  assign we_status   = wr_ok && is_mmio && (offset == OFF_STATUS);
  assign we_mtime    = wr_ok && is_mmio && (offset == OFF_MTIME);
  assign we_mtimecmp = wr_ok && is_mmio && (offset == OFF_MTIMECMP);

  assign tx_valid_o = !fifo_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign irq_o      = tmr_flag;

  sync_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (mem_data_i[7:0]),
    .head  (tx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (ram_we) ram[ram_idx] <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= '1;
      tmr_flag <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (we_mtime) mtime <= mem_data_i;
      else          mtime <= mtime + XLEN'(1);

      if (we_mtimecmp) mtimecmp <= mem_data_i;

      // A match in the current cycle wins over a write-1-to-clear.
      if (mtime == mtimecmp)                    tmr_flag <= 1'b1;
      else if (we_status && mem_data_i[ST_TMR]) tmr_flag <= 1'b0;

      if (tx_push && fifo_full && !tx_pop)      ovf <= 1'b1;
      else if (we_status && mem_data_i[ST_OVF]) ovf <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the decode can leave it unassigned and infer a latch.
  always_comb begin
    status_word           = '0;
    status_word[ST_TMR]   = tmr_flag;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = ovf;

    mem_data_o = '0;
    if (is_ram) begin
      mem_data_o = ram[ram_idx];
    end else if (is_mmio) begin
      case (offset)
        OFF_STATUS:   mem_data_o = status_word;
        OFF_MTIME:    mem_data_o = mtime;
        OFF_MTIMECMP: mem_data_o = mtimecmp;
        default:      mem_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a read/write vector table, a TX byte
// scoreboard, and hand-written sequences for FIFO, timer and reset corners.
module tb_mem_responder;

  localparam logic [31:0] A_TXDATA   = 32'h1000_0000;
  localparam logic [31:0] A_STATUS   = 32'h1000_0004;
  localparam logic [31:0] A_MTIME    = 32'h1000_0008;
  localparam logic [31:0] A_MTIMECMP = 32'h1000_000C;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  mem_responder #(.XLEN(32), .RAM_AW(10), .FIFO_AW(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_we_i   = 1'b1;
    mem_addr_i = addr;
    mem_data_i = data;
    @(posedge clk_i);
    #1;
    mem_we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    mem_addr_i = addr;
    #1;
    check(name, mem_data_o, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    wr(A_TXDATA, {24'h0, b});
  endtask

  task automatic drain(input string name);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk_i);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Sink side: each handshake seen before an edge must match the next
  // expected byte in order.
  always @(negedge clk_i) begin
    if (!rst_i && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data_o);
      end else begin
        check("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, A_MTIME,       32'h0,         32'h0,         "rst_mtime"};
    vecs[1]  = '{1'b0, A_MTIMECMP,    32'h0,         32'hFFFF_FFFF, "rst_mtimecmp"};
    vecs[2]  = '{1'b0, A_STATUS,      32'h0,         32'h2,         "rst_status"};
    vecs[3]  = '{1'b0, A_TXDATA,      32'h0,         32'h0,         "txdata_read"};
    vecs[4]  = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,         "unmapped_read"};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         "ram_wr"};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "ram_rd"};
    vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, "ram_rd_lowbits"};
    vecs[8]  = '{1'b1, 32'h0000_1010, 32'h1234_5678, 32'h0,         "ram_alias_wr"};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, "ram_alias_rd"};
    vecs[10] = '{1'b1, 32'h2000_0000, 32'h0000_0005, 32'h0,         "unmapped_wr"};
    vecs[11] = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,         "unmapped_rd"};
    vecs[12] = '{1'b1, 32'h3000_0010, 32'hCAFE_F00D, 32'h0,         "other_region_wr"};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, "ram_untouched"};
    vecs[14] = '{1'b1, 32'h0000_0014, 32'hA5A5_0F0F, 32'h0,         "ram_wr2"};
    vecs[15] = '{1'b0, 32'h0000_0014, 32'h0,         32'hA5A5_0F0F, "ram_rd2"};

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // FIFO fill past depth with the sink stalled, then drain.
    tx_ready_i = 1'b0;
    for (int b = 8'h41; b <= 8'h49; b++) push_byte(8'(b), b != 8'h49);
    rd(A_STATUS, 32'hC, "fill_status");
    check("fill_head", {24'h0, tx_data_o}, 32'h41);
    drain("fill_drain");
    tx_ready_i = 1'b0;
    rd(A_STATUS, 32'hA, "drained_status");
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, 32'h2, "ovf_cleared");

    // Push into an empty FIFO: no bypass, valid rises after the edge.
    mem_we_i   = 1'b1;
    mem_addr_i = A_TXDATA;
    mem_data_i = 32'h51;
    exp_q.push_back(8'h51);
    #1;
    check("no_bypass", {31'h0, tx_valid_o}, 32'h0);
    @(posedge clk_i);
    #1;
    mem_we_i = 1'b0;
    check("valid_next", {31'h0, tx_valid_o}, 32'h1);
    for (int b = 8'h52; b <= 8'h58; b++) push_byte(8'(b), 1'b1);
    rd(A_STATUS, 32'h4, "full_status");

    // Push while full with a pop in the same cycle.
    tx_ready_i = 1'b1;
    mem_we_i   = 1'b1;
    mem_addr_i = A_TXDATA;
    mem_data_i = 32'h5A;
    exp_q.push_back(8'h5A);
    @(posedge clk_i);
    #1;
    mem_we_i   = 1'b0;
    tx_ready_i = 1'b0;
    rd(A_STATUS, 32'h4, "pushpop_status");
    drain("pushpop_drain");
    tx_ready_i = 1'b0;

    // Timer compare: flag rises 11 edges after loading MTIME=10 with CMP=20.
    wr(A_MTIMECMP, 32'd20);
    wr(A_MTIME, 32'd10);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 10) check("irq_before", {31'h0, irq_o}, 32'h0);
      if (k == 11) check("irq_rise", {31'h0, irq_o}, 32'h1);
    end
    wr(A_STATUS, 32'h1);
    check("irq_cleared", {31'h0, irq_o}, 32'h0);
    rd(A_STATUS, 32'h2, "status_after_clear");

    // A clear during a matching cycle loses to the set.
    wr(A_MTIMECMP, 32'd100);
    wr(A_MTIME, 32'd99);
    @(posedge clk_i);
    #1;
    rd(A_MTIME, 32'd100, "mtime_at_match");
    check("irq_pre_match", {31'h0, irq_o}, 32'h0);
    wr(A_STATUS, 32'h1);
    check("set_beats_clear", {31'h0, irq_o}, 32'h1);
    wr(A_STATUS, 32'h1);
    check("irq_cleared2", {31'h0, irq_o}, 32'h0);

    // Timer wrap.
    wr(A_MTIME, 32'hFFFF_FFFE);
    rd(A_MTIME, 32'hFFFF_FFFE, "mtime_loaded");
    @(posedge clk_i);
    #1;
    rd(A_MTIME, 32'hFFFF_FFFF, "mtime_max");
    @(posedge clk_i);
    #1;
    rd(A_MTIME, 32'h0, "mtime_wrap");

    // Reset mid-drain, with a RAM write held during the reset cycle.
    tx_ready_i = 1'b0;
    for (int b = 8'h61; b <= 8'h63; b++) push_byte(8'(b), 1'b1);
    check("queued_valid", {31'h0, tx_valid_o}, 32'h1);
    rst_i      = 1'b1;
    mem_we_i   = 1'b1;
    mem_addr_i = 32'h0000_0010;
    mem_data_i = 32'h0000_0BAD;
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    mem_we_i = 1'b0;
    exp_q.delete();
    rd(A_MTIME, 32'h0, "rst2_mtime");
    check("rst2_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("rst2_tx_data", {24'h0, tx_data_o}, 32'h0);
    rd(A_STATUS, 32'h2, "rst2_status");
    rd(A_MTIMECMP, 32'hFFFF_FFFF, "rst2_mtimecmp");
    rd(32'h0000_0010, 32'h1234_5678, "rst2_ram_blocked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
